// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative RV32M multiply/divide sequencer; optional last-division cache under MDU_DIVCACHE_EN
module mdu_seq #(
    parameter int WORD_BITWIDTH = 32,
    parameter int CNT_BITWIDTH  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               funct3,
    input  logic [WORD_BITWIDTH-1:0] op_a,
    input  logic [WORD_BITWIDTH-1:0] op_b,
    input  logic                     flush,
    output logic                     stall,
    output logic                     busy,
    output logic                     done,
    output logic [WORD_BITWIDTH-1:0] result
);
    localparam int W = WORD_BITWIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t                  r_state, w_next;
    logic                    r_busy, r_done, r_neg_main, r_neg_rem;
    logic [2:0]              r_funct3;
    logic [CNT_BITWIDTH-1:0] r_cnt;
    logic [W-1:0]            r_acc, r_q, r_opd, r_result;

    logic         w_accept, w_is_div, w_a_signed, w_b_signed, w_sign_a, w_sign_b;
    logic         w_div_zero, w_ovf, w_special, w_hit, w_div_ok;
    logic [W-1:0] w_mag_a, w_mag_b, w_quo, w_rem, w_fix_result, w_hit_result;
    logic [W:0]   w_mul_sum, w_div_trial;
    logic [2*W-1:0] w_prod, w_prod_fix;

    assign w_accept   = (r_state == S_IDLE) & start & ~flush;
    assign w_is_div   = funct3[2];
    assign w_a_signed = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
    assign w_b_signed = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
    assign w_sign_a   = w_a_signed & op_a[W-1];
    assign w_sign_b   = w_b_signed & op_b[W-1];
    assign w_mag_a    = w_sign_a ? -op_a : op_a;
    assign w_mag_b    = w_sign_b ? -op_b : op_b;
    assign w_div_zero = w_is_div & (op_b == '0);
    assign w_ovf      = w_is_div & ~funct3[0] & (op_a == {1'b1, {(W-1){1'b0}}}) & (op_b == '1);
    assign w_special  = w_div_zero | w_ovf;

    // Multiply: {r_acc, r_q} is the product register, multiplier shifts out of r_q.
    assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opd} : '0);
    // Divide: r_acc is the partial remainder, dividend shifts out of r_q as quotient shifts in.
    assign w_div_trial = {r_acc, r_q[W-1]} - {1'b0, r_opd};
    assign w_div_ok    = ~w_div_trial[W];

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_main ? -w_prod : w_prod;
    assign w_quo      = r_neg_main ? -r_q : r_q;
    assign w_rem      = r_neg_rem ? -r_acc : r_acc;

    always_comb begin
        w_fix_result = w_rem;
        case (r_funct3)
            3'b000:                 w_fix_result = w_prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: w_fix_result = w_prod_fix[2*W-1:W];
            3'b100, 3'b101:         w_fix_result = w_quo;
            default:                w_fix_result = w_rem;
        endcase
    end

`ifdef MDU_DIVCACHE_EN
    logic         r_c_valid, r_c_signed;
    logic [W-1:0] r_c_a, r_c_b, r_c_quo, r_c_rem, r_a_raw, r_b_raw;

    assign w_hit = w_is_div & r_c_valid & (op_a == r_c_a) & (op_b == r_c_b) & (funct3[0] != r_c_signed);
    assign w_hit_result = funct3[1] ? r_c_rem : r_c_quo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_valid  <= 1'b0;
            r_c_signed <= 1'b0;
            r_c_a      <= '0;
            r_c_b      <= '0;
            r_c_quo    <= '0;
            r_c_rem    <= '0;
            r_a_raw    <= '0;
            r_b_raw    <= '0;
        end else begin
            if (w_accept) begin
                r_a_raw <= op_a;
                r_b_raw <= op_b;
            end
            if ((r_state == S_FIX) && !flush && r_funct3[2]) begin
                r_c_valid  <= 1'b1;
                r_c_signed <= ~r_funct3[0];
                r_c_a      <= r_a_raw;
                r_c_b      <= r_b_raw;
                r_c_quo    <= w_quo;
                r_c_rem    <= w_rem;
            end
        end
    end
`else
    assign w_hit        = 1'b0;
    assign w_hit_result = '0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_hit ? S_DONE : (w_special ? S_FIX : S_CALC);
            S_CALC: if (r_cnt == CNT_BITWIDTH'(1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    assign stall  = ~flush & (((r_state == S_IDLE) & start) | (r_state == S_CALC) | (r_state == S_FIX));
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_opd      <= '0;
            r_funct3   <= '0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
            if (!flush) begin
                case (r_state)
                    S_IDLE: if (w_accept) begin
                        r_funct3   <= funct3;
                        r_cnt      <= CNT_BITWIDTH'(W);
                        r_acc      <= '0;
                        r_neg_main <= w_sign_a ^ w_sign_b;
                        r_neg_rem  <= w_sign_a;
                        if (w_div_zero) begin
                            r_q        <= '1;
                            r_acc      <= op_a;
                            r_neg_main <= 1'b0;
                            r_neg_rem  <= 1'b0;
                        end else if (w_ovf) begin
                            r_q        <= op_a;
                            r_neg_main <= 1'b0;
                            r_neg_rem  <= 1'b0;
                        end else if (w_is_div) begin
                            r_q   <= w_mag_a;
                            r_opd <= w_mag_b;
                        end else begin
                            r_q   <= w_mag_b;
                            r_opd <= w_mag_a;
                        end
                        if (w_hit) r_result <= w_hit_result;
                    end
                    S_CALC: begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_funct3[2]) begin
                            r_acc <= w_div_ok ? w_div_trial[W-1:0] : {r_acc[W-2:0], r_q[W-1]};
                            r_q   <= {r_q[W-2:0], w_div_ok};
                        end else begin
                            r_acc <= w_mul_sum[W:1];
                            r_q   <= {w_mul_sum[0], r_q[W-1:1]};
                        end
                    end
                    S_FIX: r_result <= w_fix_result;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq: vector table, corner sequences, randomized ops vs reference model
module tb_mdu_seq;
    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        stall, busy, done;
    logic [31:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    bit          c_valid, c_s;
    logic [31:0] c_a, c_b;
    logic [31:0] last_exp;

    mdu_seq #(.WORD_BITWIDTH(32), .CNT_BITWIDTH(6)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int si_a, si_b;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        si_a = a;
        si_b = b;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return 32'(si_a / si_b);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return 32'(si_a % si_b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2]) begin
`ifdef MDU_DIVCACHE_EN
            if (c_valid && a == c_a && b == c_b && c_s == !f3[0]) return 1;
`endif
            if (b == 0) return 2;
            if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
        end
        return 34;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the edge that leaves DONE.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int nstall, output int nbusy);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        lat = -1; nstall = 0; nbusy = 0; res = '0;
        for (int k = 0; k < 100 && lat < 0; k++) begin
            @(negedge clk);
            if (stall) nstall++;
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                res = result;
            end else begin
                @(posedge clk); #1;
                start = 1'($urandom_range(0, 1));
                op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_check(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] res;
        int lat, ns, nb, elat;
        elat = ref_lat(f3, a, b);
        run_op(f3, a, b, res, lat, ns, nb);
        check({name, " result"}, res, exp);
        check({name, " latency"}, lat, elat);
        check({name, " stall cycles"}, ns, elat);
        check({name, " busy cycles"}, nb, elat);
        if (f3[2] && lat >= 0) begin
            c_valid = 1'b1; c_a = a; c_b = b; c_s = !f3[0];
        end
        last_exp = exp;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[14];

    initial begin
        int nd;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        vecs[3]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        vecs[4]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vecs[5]  = '{3'd5, 32'd100,      32'd7,        32'd14};
        vecs[6]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF};
        vecs[7]  = '{3'd7, 32'd5,        32'd0,        32'd5};
        vecs[8]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[9]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        vecs[10] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[11] = '{3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF};
        vecs[12] = '{3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
        vecs[13] = '{3'd7, 32'd100,      32'd7,        32'd2};

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        c_valid = 1'b0; c_s = 1'b0; c_a = '0; c_b = '0; last_exp = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset stall", stall, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++)
            do_check($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);

        do_check("cache div", 3'd4, 32'd100, 32'd7, 32'd14);
        do_check("cache rem", 3'd6, 32'd100, 32'd7, 32'd2);

        // Flush ten cycles into a divide: no done, result holds.
        start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush stall", stall, 0);
        @(posedge clk); #1 flush = 1'b0;
        nd = 0;
        @(negedge clk);
        check("flush busy", busy, 0);
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("flush no done", nd, 0);
        check("flush result held", result, last_exp);
        @(posedge clk); #1;
        do_check("mul after flush", 3'd0, 32'd3, 32'd4, 32'd12);
        do_check("div after flush", 3'd4, 32'd1000, 32'd7, 32'd142);

        // Flush beats a simultaneous start.
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd5;
        @(negedge clk);
        check("start+flush stall", stall, 0);
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("start+flush busy", busy, 0);
        check("start+flush result", result, last_exp);
        @(posedge clk); #1;

        // Reset in the middle of a multiply.
        start = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        c_valid = 1'b0; last_exp = '0;
        nd = 0;
        @(negedge clk);
        check("midrst busy", busy, 0);
        check("midrst result", result, 0);
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("midrst no done", nd, 0);
        @(posedge clk); #1;
        do_check("rem after rst", 3'd6, 32'd100, 32'd7, 32'd2);

        for (int i = 0; i < 150; i++) begin
            rf = 3'($urandom);
            ra = pick();
            rb = pick();
            do_check($sformatf("rand%0d f3=%0d a=%h b=%h", i, rf, ra, rb), rf, ra, rb, ref_res(rf, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer attached beside the EX-stage ALU; executes RV32M ops (funct7=0000001, opcode 0110011) the single-cycle ALU cannot.
- Accepts one operation at a time from EX (operands after forwarding) and runs an iterative shift-add / restoring-divide datapath.
- Drives a pipeline stall until the result is ready; the result is muxed into ALUresult on the done cycle.

Parameters:
- WORD_BITWIDTH, 32, operand/result width; must be even, >=8.
- CNT_BITWIDTH, 6, iteration counter width; must satisfy 2^CNT_BITWIDTH > WORD_BITWIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  EX holds an M-op; sampled only in IDLE.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  WORD_BITWIDTH  rs1 value (forwarded).
- op_b  input  WORD_BITWIDTH  rs2 value (forwarded).
- flush  input  1  abort the in-flight op (branch taken / pipeline flush).
- stall  output  1  freeze IF/ID/EX (combinational).
- busy  output  1  registered; high in CALC, FIX and DONE.
- done  output  1  registered one-cycle pulse; result is valid.
- result  output  WORD_BITWIDTH  registered; holds its value until the next done.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset: state=IDLE, busy=0, done=0, result=0, counter=0, internal accumulators=0.
- IDLE with start=1 and flush=0:
  - Latch funct3.
  - Compute magnitudes: op_a is signed for MULH/MULHSU/DIV/REM; op_b is signed for MULH/DIV/REM.
  - Record result sign: product sign = sign_a^sign_b; quotient sign = sign_a^sign_b; remainder sign = sign_a.
  - Load counter=WORD_BITWIDTH.
  - Go to CALC, or to FIX on a special case.
- Special cases, decided in IDLE; they skip CALC and go straight to FIX:
  - Divide by zero: quotient=all ones, remainder=op_a.
  - Signed overflow (op_a=100..0, op_b=all ones, DIV/REM): quotient=op_a, remainder=0.
- CALC: one iteration per cycle, counter decrements; leave when counter reaches 1 → FIX.
  - Multiply: 2*WORD_BITWIDTH-bit product register, shift-add.
  - Divide: restoring algorithm, one quotient bit per cycle.
- FIX (1 cycle):
  - Apply two's-complement sign correction.
  - Select the output: low word for MUL, high word for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register it into result; go to DONE.
- DONE (1 cycle): done=1; go to IDLE unconditionally. Start is not sampled in DONE.
- Latency: start sampled at edge N → done high in cycle N+WORD_BITWIDTH+2 (34 for 32-bit). Special cases → done in cycle N+2.
- Back-to-back ops: the earliest next start is accepted in the IDLE cycle after DONE.
- stall = ~flush & ((state==IDLE & start) | state==CALC | state==FIX). Stall is low in the DONE cycle so EX can advance with the result.
- flush=1 in any state: next state=IDLE, busy=0, done stays 0, result is unchanged. Flush wins over a simultaneous start.
- rst mid-operation: same as the reset values; no done is issued.
- start/op_a/op_b/funct3 changes while busy are ignored; operands are captured only at acceptance.

Optional Feature:
- MDU_DIVCACHE_EN defined:
  - Store op_a, op_b, signedness, quotient and remainder of the last division that completed (reached DONE).
  - A new DIV/DIVU/REM/REMU with identical op_a, op_b and signedness hits: IDLE→DONE directly, result taken from the cache, done in cycle N+1, stall high only in the start cycle.
  - Cache is invalidated by rst. Flushed divisions do not update it. Multiplies neither read nor modify it.
- Undefined: no cache storage; every division takes the normal path.

Test Plan:
- MUL op_a=7, op_b=-3 (0xFFFFFFFD) → result 0xFFFFFFEB, done exactly 34 cycles after start, stall high cycles 0..33.
- MULHU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → result 0xFFFFFFFE; MULHSU op_a=-1, op_b=2 → 0xFFFFFFFF.
- DIV op_a=-7, op_b=2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; DIVU 100/7 → 14.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5; DIV 0x80000000/-1 → 0x80000000 and REM → 0; done 2 cycles after start.
- flush asserted 10 cycles into a DIV → IDLE next cycle, no done pulse, result unchanged; a new MUL 3*4 immediately after → 12.
- MDU_DIVCACHE_EN: DIV 100/7 → 14 (34 cycles), then REM 100/7 → 2 with done 1 cycle after start; after rst the same REM takes 34 cycles.
